act_vec_serializer: RTL and testbench

Drains LENGTH-element activation vectors produced by the ReLU stage and streams them toward the unified buffer as LANES-element beats over a valid/ready handshake. Two vector slots (ping-pong) let the ReLU stage deposit the next vector while the current one drains. Element order, values and bit patterns pass through unchanged; this block only buffers and narrows.

---
 rtl/ttpu_pkg.sv | 12 +
 rtl/act_vec_serializer.sv | 90 +++++++++
 tb/tb_act_vec_serializer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ttpu_pkg.sv
// ttpu_pkg: shared datapath defaults for the ReLU -> unified-buffer activation path.
package ttpu_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned LENGTH     = 64;
  localparam int unsigned LANES      = 4;
  localparam int unsigned BEATS      = LENGTH / LANES;
  localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [DATA_WIDTH-1:0] elem_t;

endpackage

// File: rtl/act_vec_serializer.sv
// act_vec_serializer: two-slot ping-pong buffer that narrows LENGTH-element
// activation vectors into LANES-element beats over a valid/ready handshake.
module act_vec_serializer
  import ttpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ttpu_pkg::DATA_WIDTH,
  parameter int unsigned LENGTH     = ttpu_pkg::LENGTH,
  parameter int unsigned LANES      = ttpu_pkg::LANES,
  localparam int unsigned BEATS     = LENGTH / LANES,
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_vec [0:LENGTH-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data [0:LANES-1],
  output logic [BEAT_W-1:0]     out_beat,
  output logic                  out_last,
  input  logic                  flush
);

  localparam int unsigned IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  if (LENGTH % LANES != 0) begin : g_bad_geometry
    $error("act_vec_serializer: LENGTH must be a multiple of LANES");
  end

  logic [DATA_WIDTH-1:0] slot [0:1][0:LENGTH-1];
  logic [1:0]            full;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [BEAT_W-1:0]     beat;

  logic capture;
  logic xfer;
  logic last_beat;

  // Handshake decode; in_ready depends only on registered state.
  always_comb begin
    in_ready  = !full[wr_ptr];
    out_valid = full[rd_ptr];
    last_beat = (beat == BEAT_W'(BEATS - 1));
    out_last  = out_valid && last_beat;
    out_beat  = beat;
    capture   = in_valid && in_ready;
    xfer      = out_valid && out_ready;
  end

  // Beat mux: lane k of the current beat comes from element beat*LANES+k of the read slot.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign out_data[k] = slot[rd_ptr][IDX_W'(int'(beat) * LANES + k)];
  end

  // Slot capture, occupancy tracking and beat sequencing; flush overrides both sides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot   <= '{default: '0};
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      beat   <= '0;
    end else if (flush) begin
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      beat   <= '0;
    end else begin
      // Capture and release always touch different bits of full: a slot being
      // drained is full, so it can never be the write slot in the same cycle.
      if (capture) begin
        slot[wr_ptr] <= in_vec;
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
      if (xfer) begin
        if (last_beat) begin
          beat         <= '0;
          full[rd_ptr] <= 1'b0;
          rd_ptr       <= ~rd_ptr;
        end else begin
          beat <= beat + BEAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_act_vec_serializer.sv
// tb_act_vec_serializer: scoreboard plus table-driven and directed checks.
module tb_act_vec_serializer;
  import ttpu_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_vec [0:LENGTH-1];
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data [0:LANES-1];
  logic [BEAT_W-1:0]     out_beat;
  logic                  out_last;
  logic                  flush;

  act_vec_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LENGTH    (LENGTH),
    .LANES     (LANES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_beat (out_beat),
    .out_last (out_last),
    .flush    (flush)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp(input int unsigned base);
    for (int i = 0; i < LENGTH; i++) in_vec[i] = DATA_WIDTH'(base + i);
  endtask

  // Scoreboard: elements queued at capture, consumed lane by lane at each beat transfer.
  logic [DATA_WIDTH-1:0] sb [$];
  int unsigned           mbeat = 0;
  int unsigned           elems_seen = 0;
  logic                  stall_v = 1'b0;
  logic [DATA_WIDTH-1:0] held_data [0:LANES-1];
  logic [BEAT_W-1:0]     held_beat;

  // Outputs and inputs are both settled at the falling edge and describe the next rising edge.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
      mbeat   = 0;
      stall_v = 1'b0;
    end else begin
      if (stall_v && out_valid) begin
        chk("stall_beat", 32'(out_beat), 32'(held_beat));
        for (int k = 0; k < LANES; k++) chk("stall_data", 32'(out_data[k]), 32'(held_data[k]));
      end
      stall_v = 1'b0;
      if (out_valid) begin
        chk("out_beat", 32'(out_beat), 32'(mbeat));
        chk("out_last", 32'(out_last), 32'(mbeat == BEATS - 1));
        if (out_ready) begin
          for (int k = 0; k < LANES; k++) begin
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL sb_underflow: got beat with lane %0d data 0x%0h expected no output", k, out_data[k]);
            end else begin
              logic [DATA_WIDTH-1:0] e;
              e = sb.pop_front();
              if (out_data[k] !== e) begin
                failures++;
                $display("FAIL sb_data: lane %0d beat %0d got 0x%0h expected 0x%0h", k, mbeat, out_data[k], e);
              end
            end
          end
          elems_seen += LANES;
          mbeat = (mbeat == BEATS - 1) ? 0 : mbeat + 1;
        end else begin
          stall_v   = 1'b1;
          held_beat = out_beat;
          for (int k = 0; k < LANES; k++) held_data[k] = out_data[k];
        end
      end else begin
        chk("out_last_idle", 32'(out_last), 32'(0));
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < LENGTH; i++) sb.push_back(in_vec[i]);
      end
    end
  end

  typedef struct {
    int unsigned           idx;
    logic [DATA_WIDTH-1:0] val;
    int unsigned           beat;
    int unsigned           lane;
  } pat_t;
  pat_t pats [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pats[0] = '{idx: 5,  val: 16'h7FFF, beat: 1,  lane: 1};
    pats[1] = '{idx: 22, val: 16'h8000, beat: 5,  lane: 2};
    pats[2] = '{idx: 63, val: 16'hFFFF, beat: 15, lane: 3};
    pats[3] = '{idx: 0,  val: 16'h8000, beat: 0,  lane: 0};
    pats[4] = '{idx: 40, val: 16'h7FFF, beat: 10, lane: 0};
    pats[5] = '{idx: 13, val: 16'h0001, beat: 3,  lane: 1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    set_ramp(0);
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_beat", 32'(out_beat), 0);
    for (int k = 0; k < LANES; k++) chk("rst_out_data", 32'(out_data[k]), 0);
    reset = 1'b0;
    tick();

    // Single ramp vector, one beat per cycle.
    set_ramp(0);
    in_valid = 1'b1;
    chk("t1_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("t1_latency_valid", 32'(out_valid), 1);
    chk("t1_latency_beat", 32'(out_beat), 0);
    chk("t1_beat0_lane3", 32'(out_data[3]), 3);
    out_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      chk("t1_valid", 32'(out_valid), 1);
      tick();
    end
    chk("t1_done", 32'(out_valid), 0);
    chk("t1_elems", elems_seen, LENGTH);
    out_ready = 1'b0;

    // Fill both slots with no drain, then drain back to back.
    set_ramp(100);
    in_valid = 1'b1;
    tick();
    chk("t2_ready_after_a", 32'(in_ready), 1);
    set_ramp(200);
    tick();
    in_valid = 1'b0;
    chk("t2_ready_after_b", 32'(in_ready), 0);
    tick(); tick();
    chk("t2_hold_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    for (int c = 0; c < 2 * BEATS; c++) begin
      chk("t2_contig_valid", 32'(out_valid), 1);
      chk("t2_contig_beat", 32'(out_beat), 32'(c % BEATS));
      chk("t2_in_ready", 32'(in_ready), 32'(c >= BEATS));
      tick();
    end
    chk("t2_done", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Eight random vectors streamed with 50% out_ready.
    begin
      int sent = 0;
      logic cap;
      elems_seen = 0;
      for (int i = 0; i < LENGTH; i++) in_vec[i] = DATA_WIDTH'($urandom);
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        out_ready = 1'($urandom_range(0, 1));
        cap = in_valid && in_ready;
        tick();
        if (cap) begin
          sent++;
          if (sent == 8) in_valid = 1'b0;
          else for (int i = 0; i < LENGTH; i++) in_vec[i] = DATA_WIDTH'($urandom);
        end
        if (sent == 8 && sb.size() == 0 && !out_valid) break;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("t3_sent", sent, 8);
      chk("t3_elems", elems_seen, 8 * LENGTH);
      chk("t3_sb_empty", sb.size(), 0);
    end

    // Boundary bit patterns land verbatim at their lanes.
    for (int i = 0; i < LENGTH; i++) in_vec[i] = '0;
    for (int j = 0; j < 6; j++) in_vec[pats[j].idx] = pats[j].val;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) begin
      chk("t4_beat", 32'(out_beat), b);
      for (int j = 0; j < 6; j++)
        if (pats[j].beat == b) chk("t4_pattern", 32'(out_data[pats[j].lane]), 32'(pats[j].val));
      tick();
    end
    chk("t4_done", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Reset during beat 7 of A with B buffered.
    set_ramp(300);
    in_valid = 1'b1;
    tick();
    set_ramp(400);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int b = 0; b < 7; b++) tick();
    chk("t5_pre_beat", 32'(out_beat), 7);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_ready", 32'(in_ready), 1);
    chk("t5_rst_beat", 32'(out_beat), 0);
    tick(); tick();
    reset = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("t5_post_valid", 32'(out_valid), 0);
    set_ramp(500);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_c_valid", 32'(out_valid), 1);
    chk("t5_c_beat", 32'(out_beat), 0);
    chk("t5_c_data0", 32'(out_data[0]), 500);
    out_ready = 1'b1;
    for (int b = 0; b < BEATS; b++) tick();
    chk("t5_c_done", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Flush coincident with capture and beat transfer.
    set_ramp(600);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    set_ramp(700);
    in_valid = 1'b1;
    flush = 1'b1;
    chk("t6_pre_ready", 32'(in_ready), 1);
    chk("t6_pre_valid", 32'(out_valid), 1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_ready", 32'(in_ready), 1);
    chk("t6_beat", 32'(out_beat), 0);
    tick(); tick();
    chk("t6_no_capture", 32'(out_valid), 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
